// File: rtl/clock_disp_pkg.sv
// Shared constants, types and helpers for the multiplexed clock display.
package clock_disp_pkg;

  // Active-low seven-segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // Digit slot order, rightmost digit first
  typedef enum logic [2:0] {
    DIG_SEC_ONES = 3'd0,
    DIG_SEC_TENS = 3'd1,
    DIG_MIN_ONES = 3'd2,
    DIG_MIN_TENS = 3'd3,
    DIG_HR_ONES  = 3'd4,
    DIG_HR_TENS  = 3'd5
  } digit_idx_e;

  // Largest legal value of each time field
  localparam logic [5:0] SEC_MIN_MAX = 6'd59;
  localparam logic [4:0] HR_MAX      = 5'd23;

  // One coherent copy of the time, loaded once per display frame
  typedef struct packed {
    logic [4:0] hr;
    logic [5:0] min;
    logic [5:0] sec;
  } time_snap_t;

  // Binary to {tens, ones} BCD by successive compare/subtract (no divider).
  // Valid for 0..63, which covers every value a 6-bit field can hold.
  function automatic logic [7:0] bin_to_bcd(input logic [5:0] value);
    logic [5:0] rem_v;
    logic [3:0] tens_v;
    rem_v  = value;
    tens_v = 4'd0;
    if (rem_v >= 6'd40) begin
      rem_v  = rem_v - 6'd40;
      tens_v = tens_v + 4'd4;
    end else begin
      rem_v  = rem_v;
    end
    if (rem_v >= 6'd20) begin
      rem_v  = rem_v - 6'd20;
      tens_v = tens_v + 4'd2;
    end else begin
      rem_v  = rem_v;
    end
    if (rem_v >= 6'd10) begin
      rem_v  = rem_v - 6'd10;
      tens_v = tens_v + 4'd1;
    end else begin
      rem_v  = rem_v;
    end
    return {tens_v, rem_v[3:0]};
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes show nothing.
module seg7_encoder
  import clock_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup from digit value to segment pattern
  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/clock_display_mux.sv
// Six-digit HH:MM:SS multiplexed LED driver with per-frame time snapshot,
// anti-ghosting blank interval, range checking and hour leading-zero blanking.
module clock_display_mux
  import clock_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter bit          HR_LZ_BLANK  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hr,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       dp
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] scan_cnt_r;
  digit_idx_e       digit_idx_r;
  digit_idx_e       digit_idx_next_s;
  logic             first_r;
  time_snap_t       snap_r;

  logic             cnt_wrap_s;
  logic             frame_wrap_s;
  logic             blank_s;

  logic [7:0]       sec_bcd_s;
  logic [7:0]       min_bcd_s;
  logic [7:0]       hr_bcd_s;
  logic             sec_ok_s;
  logic             min_ok_s;
  logic             hr_ok_s;
  logic [3:0]       digit_s;
  logic             dash_s;
  logic             lz_s;
  logic [6:0]       enc_seg_s;

  logic [6:0]       seg_next_s;
  logic [5:0]       an_next_s;
  logic             dp_next_s;
  logic [6:0]       seg_r;
  logic [5:0]       an_r;
  logic             dp_r;

  assign cnt_wrap_s   = (scan_cnt_r == CNT_W'(SCAN_DIV - 1));
  assign frame_wrap_s = cnt_wrap_s && (digit_idx_r == DIG_HR_TENS);
  assign blank_s      = (32'(scan_cnt_r) < BLANK_CYCLES);

  // Successor of the current digit slot, wrapping after the hour tens digit
  always_comb begin
    digit_idx_next_s = DIG_SEC_ONES;
    case (digit_idx_r)
      DIG_SEC_ONES: digit_idx_next_s = DIG_SEC_TENS;
      DIG_SEC_TENS: digit_idx_next_s = DIG_MIN_ONES;
      DIG_MIN_ONES: digit_idx_next_s = DIG_MIN_TENS;
      DIG_MIN_TENS: digit_idx_next_s = DIG_HR_ONES;
      DIG_HR_ONES:  digit_idx_next_s = DIG_HR_TENS;
      DIG_HR_TENS:  digit_idx_next_s = DIG_SEC_ONES;
      default:      digit_idx_next_s = DIG_SEC_ONES;
    endcase
  end

  // Scan timing and the time snapshot, loaded on the first edge out of reset
  // and at every frame wrap so a frame never mixes two different times
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_r  <= {CNT_W{1'b0}};
      digit_idx_r <= DIG_SEC_ONES;
      first_r     <= 1'b1;
      snap_r      <= '{hr: 5'd0, min: 6'd0, sec: 6'd0};
    end else begin
      first_r <= 1'b0;
      if (cnt_wrap_s) begin
        scan_cnt_r  <= {CNT_W{1'b0}};
        digit_idx_r <= digit_idx_next_s;
      end else begin
        scan_cnt_r  <= scan_cnt_r + CNT_W'(1);
        digit_idx_r <= digit_idx_r;
      end
      if (first_r || frame_wrap_s) begin
        snap_r <= '{hr: hr, min: min, sec: sec};
      end else begin
        snap_r <= snap_r;
      end
    end
  end

  // Pick the digit for the current slot from the snapshot, with range and
  // leading-zero qualifiers
  always_comb begin
    sec_bcd_s = bin_to_bcd(snap_r.sec);
    min_bcd_s = bin_to_bcd(snap_r.min);
    hr_bcd_s  = bin_to_bcd({1'b0, snap_r.hr});
    sec_ok_s  = (snap_r.sec <= SEC_MIN_MAX);
    min_ok_s  = (snap_r.min <= SEC_MIN_MAX);
    hr_ok_s   = (snap_r.hr <= HR_MAX);
    digit_s   = 4'd0;
    dash_s    = 1'b0;
    lz_s      = 1'b0;
    case (digit_idx_r)
      DIG_SEC_ONES: begin
        digit_s = sec_bcd_s[3:0];
        dash_s  = !sec_ok_s;
      end
      DIG_SEC_TENS: begin
        digit_s = sec_bcd_s[7:4];
        dash_s  = !sec_ok_s;
      end
      DIG_MIN_ONES: begin
        digit_s = min_bcd_s[3:0];
        dash_s  = !min_ok_s;
      end
      DIG_MIN_TENS: begin
        digit_s = min_bcd_s[7:4];
        dash_s  = !min_ok_s;
      end
      DIG_HR_ONES: begin
        digit_s = hr_bcd_s[3:0];
        dash_s  = !hr_ok_s;
      end
      DIG_HR_TENS: begin
        digit_s = hr_bcd_s[7:4];
        dash_s  = !hr_ok_s;
        lz_s    = HR_LZ_BLANK && hr_ok_s && (hr_bcd_s[7:4] == 4'd0);
      end
      default: begin
        digit_s = 4'd0;
        dash_s  = 1'b1;
        lz_s    = 1'b0;
      end
    endcase
  end

  seg7_encoder u_seg7_encoder (
    .bcd (digit_s),
    .seg (enc_seg_s)
  );

  // Next values of the pins: all dark while blanking, else one anode driven
  always_comb begin
    an_next_s  = 6'b111111;
    seg_next_s = SEG_OFF;
    dp_next_s  = 1'b1;
    if (blank_s) begin
      an_next_s  = 6'b111111;
      seg_next_s = SEG_OFF;
      dp_next_s  = 1'b1;
    end else begin
      an_next_s = ~(6'b000001 << digit_idx_r);
      if (dash_s) begin
        seg_next_s = SEG_DASH;
      end else if (lz_s) begin
        seg_next_s = SEG_OFF;
      end else begin
        seg_next_s = enc_seg_s;
      end
      if ((digit_idx_r == DIG_MIN_ONES) || (digit_idx_r == DIG_HR_ONES)) begin
        dp_next_s = 1'b0;
      end else begin
        dp_next_s = 1'b1;
      end
    end
  end

  // Output pin registers; dark immediately on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_r <= SEG_OFF;
      an_r  <= 6'b111111;
      dp_r  <= 1'b1;
    end else begin
      seg_r <= seg_next_s;
      an_r  <= an_next_s;
      dp_r  <= dp_next_s;
    end
  end

  assign seg = seg_r;
  assign an  = an_r;
  assign dp  = dp_r;

endmodule

// File: tb/tb_clock_display_mux.sv
// Self-checking bench: cycle reference model, vector table, corner sequences.
`timescale 1ns/1ps
module tb_clock_display_mux;

  localparam int S = 4;
  localparam int B = 1;
  localparam int FRAME = 6 * S;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] sec = 6'd0;
  logic [5:0] min = 6'd0;
  logic [4:0] hr = 5'd0;
  logic [6:0] seg1, seg0;
  logic [5:0] an1, an0;
  logic       dp1, dp0;

  always #5 clk = ~clk;

  clock_display_mux #(.SCAN_DIV(S), .BLANK_CYCLES(B), .HR_LZ_BLANK(1'b1)) dut (
    .clk(clk), .reset(reset), .sec(sec), .min(min), .hr(hr),
    .seg(seg1), .an(an1), .dp(dp1));

  clock_display_mux #(.SCAN_DIV(S), .BLANK_CYCLES(B), .HR_LZ_BLANK(1'b0)) dut0 (
    .clk(clk), .reset(reset), .sec(sec), .min(min), .hr(hr),
    .seg(seg0), .an(an0), .dp(dp0));

  int errors = 0;
  int checks = 0;
  int n = 0;                 // rising edges since reset release
  logic [5:0] m_sec = 6'd0;  // model snapshot
  logic [5:0] m_min = 6'd0;
  logic [4:0] m_hr  = 5'd0;
  logic [6:0] digit_code [10];
  bit dc_en = 1'b0;
  int dc_div = 0;

  typedef struct {
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    int         slot;
    logic [6:0] seg1;
    logic [6:0] seg0;
    logic [5:0] an;
    logic       dp;
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  // Expected pattern from the time rules: decimal split, range, leading zero
  function automatic logic [6:0] exp_seg(input int slot, input logic [5:0] s,
                                         input logic [5:0] m, input logic [4:0] h,
                                         input bit lz);
    int val;
    int lim;
    int d;
    case (slot / 2)
      0:       begin val = int'(s); lim = 59; end
      1:       begin val = int'(m); lim = 59; end
      default: begin val = int'(h); lim = 23; end
    endcase
    if (val > lim) return 7'b0111111;
    d = (slot % 2 == 0) ? val % 10 : val / 10;
    if (lz && slot == 5 && d == 0) return 7'h7F;
    return digit_code[d];
  endfunction

  // One clock: advance the model, compare both instances, step the time source
  task automatic tick();
    int st, cnt, slot;
    bit blank;
    logic [5:0] o_s, o_m;
    logic [4:0] o_h;
    logic [5:0] e_an;
    @(posedge clk);
    n++;
    o_s = m_sec; o_m = m_min; o_h = m_hr;
    if (n == 1 || n % FRAME == 0) begin
      m_sec = sec; m_min = min; m_hr = hr;
    end
    #1;
    st = n - 1;
    cnt = st % S;
    slot = (st / S) % 6;
    blank = (cnt < B);
    e_an = blank ? 6'h3F : ~(6'd1 << slot);
    check("an", {1'b0, an1}, {1'b0, e_an});
    check("an_nolz", {1'b0, an0}, {1'b0, e_an});
    check("seg", seg1, blank ? 7'h7F : exp_seg(slot, o_s, o_m, o_h, 1'b1));
    check("seg_nolz", seg0, blank ? 7'h7F : exp_seg(slot, o_s, o_m, o_h, 1'b0));
    check("dp", {6'd0, dp1}, {6'd0, ((!blank && (slot == 2 || slot == 4)) ? 1'b0 : 1'b1)});
    if (dc_en) begin
      dc_div++;
      if (dc_div == 10) begin
        dc_div = 0;
        if (sec == 6'd59) begin
          sec = 6'd0;
          if (min == 6'd59) begin
            min = 6'd0;
            hr = (hr == 5'd23) ? 5'd0 : hr + 5'd1;
          end else begin
            min = min + 6'd1;
          end
        end else begin
          sec = sec + 6'd1;
        end
      end
    end
  endtask

  // Assert reset between edges, check outputs dark at once, then release
  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #0.1;
    check("rst_an", {1'b0, an1}, 7'h3F);
    check("rst_seg", seg1, 7'h7F);
    check("rst_dp", {6'd0, dp1}, 7'd1);
    check("rst_seg_nolz", seg0, 7'h7F);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    m_sec = 6'd0; m_min = 6'd0; m_hr = 5'd0;
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit found;
    digit_code = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    tbl[0]  = '{6'd56, 6'd34, 5'd12, 0, 7'h02, 7'h02, 6'h3E, 1'b1};
    tbl[1]  = '{6'd56, 6'd34, 5'd12, 1, 7'h12, 7'h12, 6'h3D, 1'b1};
    tbl[2]  = '{6'd56, 6'd34, 5'd12, 2, 7'h19, 7'h19, 6'h3B, 1'b0};
    tbl[3]  = '{6'd56, 6'd34, 5'd12, 3, 7'h30, 7'h30, 6'h37, 1'b1};
    tbl[4]  = '{6'd56, 6'd34, 5'd12, 4, 7'h24, 7'h24, 6'h2F, 1'b0};
    tbl[5]  = '{6'd56, 6'd34, 5'd12, 5, 7'h79, 7'h79, 6'h1F, 1'b1};
    tbl[6]  = '{6'd0,  6'd0,  5'd7,  4, 7'h78, 7'h78, 6'h2F, 1'b0};
    tbl[7]  = '{6'd0,  6'd0,  5'd7,  5, 7'h7F, 7'h40, 6'h1F, 1'b1};
    tbl[8]  = '{6'd12, 6'd60, 5'd3,  0, 7'h24, 7'h24, 6'h3E, 1'b1};
    tbl[9]  = '{6'd12, 6'd60, 5'd3,  2, 7'h3F, 7'h3F, 6'h3B, 1'b0};
    tbl[10] = '{6'd12, 6'd60, 5'd3,  3, 7'h3F, 7'h3F, 6'h37, 1'b1};
    tbl[11] = '{6'd12, 6'd60, 5'd3,  4, 7'h30, 7'h30, 6'h2F, 1'b0};

    // Release from reset: blank first, digit 0 from scan count 1
    sec = 6'd5; min = 6'd4; hr = 5'd3;
    do_reset();
    tick();
    check("rel_blank_an", {1'b0, an1}, 7'h3F);
    tick();
    check("rel_dig0_an", {1'b0, an1}, 7'h3E);
    check("rel_dig0_seg", seg1, 7'h12);
    run_to(S + 1);   // stop mid-scan before the next reset

    // Vector table: each row checked at count 1 of its slot in the first frame
    for (int i = 0; i < 12; i++) begin
      sec = tbl[i].sec; min = tbl[i].min; hr = tbl[i].hr;
      do_reset();
      run_to(tbl[i].slot * S + 2);
      check($sformatf("tbl%0d_an", i), {1'b0, an1}, {1'b0, tbl[i].an});
      check($sformatf("tbl%0d_seg", i), seg1, tbl[i].seg1);
      check($sformatf("tbl%0d_seg_nolz", i), seg0, tbl[i].seg0);
      check($sformatf("tbl%0d_dp", i), {6'd0, dp1}, {6'd0, tbl[i].dp});
      tick();
      check($sformatf("tbl%0d_seg_hold", i), seg1, tbl[i].seg1);
    end

    // Seconds 59 -> 0 during slot 3: new value only from the next frame
    sec = 6'd59; min = 6'd0; hr = 5'd10;
    do_reset();
    run_to(2);
    check("tear_s0_f0", seg1, 7'h10);
    run_to(S + 2);
    check("tear_s1_f0", seg1, 7'h12);
    run_to(3 * S + 2);
    sec = 6'd0;
    run_to(5 * S + 2);
    check("tear_s5_f0", seg1, 7'h79);
    run_to(FRAME + 2);
    check("tear_s0_f1", seg1, 7'h40);
    run_to(FRAME + S + 2);
    check("tear_s1_f1", seg1, 7'h40);

    // Running clock source through 23:59:59 -> 00:00:00
    sec = 6'd58; min = 6'd59; hr = 5'd23;
    dc_div = 0;
    dc_en = 1'b1;
    do_reset();
    k = 0;
    while (!(sec == 6'd0 && min == 6'd0 && hr == 5'd0) && k < 40) begin
      tick();
      k++;
    end
    check("rollover_reached", {6'd0, (k < 40)}, 7'd1);
    k = 0;
    found = 1'b0;
    while (!found && k < FRAME + S + 2) begin
      tick();
      if (an1 == 6'h2F && seg1 == 7'h40) found = 1'b1;
      k++;
    end
    check("rollover_hr_ones_zero", {6'd0, found}, 7'd1);
    repeat (60) tick();
    dc_en = 1'b0;

    // Random inputs, including out-of-range fields, with a mid-run reset
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        sec = 6'($urandom_range(0, 63));
        min = 6'($urandom_range(0, 63));
        hr  = 5'($urandom_range(0, 31));
      end
      if (i == 400) do_reset();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_display_mux.md
CLOCK_DISPLAY_MUX -- requirements
Module: clock_display_mux

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000: clk cycles per digit slot, legal range 2..65535.
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 2: anode-off cycles at the start of each slot (anti-ghosting), legal range 0..SCAN_DIV-1.
REQ-003 The block SHALL have parameter HR_LZ_BLANK, default 1: when 1, the hour tens digit is blanked if it is zero.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-006 The block SHALL have port sec, input, 6 bits: binary seconds from digital_clock, valid range 0..59.
REQ-007 The block SHALL have port min, input, 6 bits: binary minutes, valid range 0..59.
REQ-008 The block SHALL have port hr, input, 5 bits: binary hours, valid range 0..23.
REQ-009 The block SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-010 The block SHALL have port an, output, 6 bits: digit anodes, active-low; an[0] is the rightmost digit.
REQ-011 The block SHALL have port dp, output, 1 bit: decimal point, active-low.

Function
REQ-012 A scan counter SHALL count 0..SCAN_DIV-1 and wrap to 0; on each wrap the digit index SHALL advance 0->1->...->5->0.
REQ-013 Digit index mapping SHALL be: 0 = sec ones, 1 = sec tens, 2 = min ones, 3 = min tens, 4 = hr ones, 5 = hr tens.
REQ-014 sec, min and hr SHALL be captured into a snapshot register on the cycle the digit index wraps 5->0, and on the first clk edge after reset release; displayed digits SHALL come only from the snapshot, so no frame shows a torn time.
REQ-015 Binary-to-BCD conversion SHALL use compare/subtract only (no divider): tens = value/10, ones = value%10, for values 0..59.
REQ-016 Each snapshot field SHALL be checked against its range; sec or min >59, or hr >23, SHALL make both digits of that field show dash (segment g only, seg = 7'b0111111).
REQ-017 With HR_LZ_BLANK = 1, if hr tens = 0 and hr is in range, slot 5 SHALL drive seg = 7'h7F while keeping its normal anode timing.
REQ-018 During scan counter values 0..BLANK_CYCLES-1 of every slot, an SHALL be 6'b111111; for the remaining counts, an SHALL have exactly one bit low, at the current digit index.
REQ-019 dp SHALL be 0 (lit) in slots 2 and 4 whenever their anode is active, and 1 otherwise.
REQ-020 seg, an and dp SHALL be registered outputs, changing exactly one clk after the scan counter or digit index change that causes them.
REQ-021 Input changes SHALL have no effect on the outputs until the next snapshot; the worst-case display latency is 6*SCAN_DIV+1 cycles.

Reset
REQ-022 While reset = 0: scan counter = 0, digit index = 0, snapshot = 0, an = 6'b111111, seg = 7'h7F, dp = 1, all taking effect immediately and independent of clk.
REQ-023 Reset asserted mid-slot SHALL abort the scan, and the first slot after release SHALL be digit 0 with a full blanking interval.

Structure
REQ-024 Package clock_disp_pkg SHALL hold the 7-segment encodings for 0-9, the SEG_DASH and SEG_OFF constants, the digit-index constants and the field range limits (59, 23).
REQ-025 A combinational sub-module seg7_encoder (4-bit BCD in, 7-bit active-low segments out; codes 10-15 map to SEG_OFF) SHALL be used once, on the muxed digit.

Verification (SCAN_DIV=4, BLANK_CYCLES=1 unless noted)
REQ-026 Bench SHALL check: reset low mid-scan -> an=111111, seg=7F, dp=1 in the same timestep; release -> digit 0 active from scan count 1.
REQ-027 Bench SHALL check: hr=12, min=34, sec=56 held -> slots 0..5 show 6,5,4,3,2,1 with anodes 111110..011111, dp low in slots 2 and 4, and one blank cycle per slot.
REQ-028 Bench SHALL check: hr=7 with HR_LZ_BLANK=1 -> slot 5 seg=7F; with HR_LZ_BLANK=0 -> slot 5 shows the code for 0 (7'b1000000).
REQ-029 Bench SHALL check: sec changes 59->0 during slot 3 -> the current frame still shows 59, and the next frame (from the 5->0 wrap) shows 00.
REQ-030 Bench SHALL check: min=60 (out of range) -> slots 2 and 3 show dash 0111111 while the other slots decode normally.
REQ-031 Bench SHALL check: digital_clock (DIVIDER=10) drives the inputs through the 23:59:59 -> 00:00:00 rollover -> decoded display matches $display output within 6*SCAN_DIV+1 cycles.
